// File: rtl/led_matrix_scanner_if.sv
// Bitmap/enable inputs and LED-chain drive signals of the matrix scanner.
// The scanner connects through the slave modport; the driver side uses master.
interface led_matrix_scanner_if;
  logic         enable;
  logic [127:0] frame;
  logic         ser_data;
  logic         ser_clk;
  logic         ser_latch;
  logic [2:0]   row_idx;
  logic         frame_start;
  logic         busy;

  modport master (
    output enable, frame,
    input  ser_data, ser_clk, ser_latch, row_idx, frame_start, busy
  );

  modport slave (
    input  enable, frame,
    output ser_data, ser_clk, ser_latch, row_idx, frame_start, busy
  );
endinterface

// File: rtl/led_matrix_scanner.sv
// Row-at-a-time scanner for an 8x16 LED matrix driven through a chain of three
// SIPO shift registers (row-select byte followed by two column bytes).
module led_matrix_scanner #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DWELL   = 2000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_matrix_scanner_if.slave  bus
);
  localparam int unsigned PW   = $clog2(2 * CLK_DIV + 1);
  localparam int unsigned WMAX = (DWELL > CLK_DIV) ? DWELL : CLK_DIV;
  localparam int unsigned WW   = $clog2(WMAX + 1);

  localparam logic [PW-1:0] PH_RISE    = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST    = PW'(2 * CLK_DIV - 1);
  localparam logic [WW-1:0] LATCH_LAST = WW'(CLK_DIV - 1);
  localparam logic [WW-1:0] DWELL_LAST = WW'(DWELL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DWELL
  } state_t;

  state_t        state;
  logic [127:0]  frame_buf;
  logic [23:0]   shreg;
  logic [PW-1:0] phase;
  logic [4:0]    bit_cnt;
  logic [WW-1:0] wait_cnt;
  logic          data_q;
  logic          sclk_q;
  logic          latch_q;
  logic [2:0]    row_q;
  logic          fstart_q;
  logic          busy_q;

  logic [15:0]   row_bits;
  logic [23:0]   word;

  // Row r lives at frame[127-16r -: 16]; the base index is {~r, 4'hF}.
  // Row 0 is taken straight from the input because it is captured this cycle.
  always_comb begin
    row_bits = frame_buf[{~row_q, 4'hF} -: 16];
    if (row_q == 3'd0) begin
      row_bits = bus.frame[127:112];
    end
    word = {8'h80 >> row_q, row_bits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      frame_buf <= '0;
      shreg     <= '0;
      phase     <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      data_q    <= 1'b0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      row_q     <= '0;
      fstart_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.enable) begin
            state    <= S_LOAD;
            busy_q   <= 1'b1;
            row_q    <= '0;
            fstart_q <= 1'b1;
          end
        end
        S_LOAD: begin
          fstart_q <= 1'b0;
          if (!bus.enable) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            row_q  <= '0;
          end else begin
            if (row_q == 3'd0) begin
              frame_buf <= bus.frame;
            end
            data_q  <= word[23];
            shreg   <= {word[22:0], 1'b0};
            sclk_q  <= 1'b0;
            phase   <= '0;
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end
        end
        // ser_clk is registered from the phase about to be entered, so each
        // bit gives CLK_DIV low cycles followed by CLK_DIV high cycles.
        S_SHIFT: begin
          if (phase == PH_LAST) begin
            phase  <= '0;
            sclk_q <= 1'b0;
            if (bit_cnt == 5'd23) begin
              data_q   <= 1'b0;
              latch_q  <= 1'b1;
              wait_cnt <= '0;
              state    <= S_LATCH;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              data_q  <= shreg[23];
              shreg   <= {shreg[22:0], 1'b0};
            end
          end else begin
            phase  <= phase + PW'(1);
            sclk_q <= (phase >= PH_RISE);
          end
        end
        S_LATCH: begin
          if (wait_cnt == LATCH_LAST) begin
            latch_q  <= 1'b0;
            wait_cnt <= '0;
            state    <= S_DWELL;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_DWELL: begin
          if (wait_cnt == DWELL_LAST) begin
            wait_cnt <= '0;
            row_q    <= row_q + 3'd1;
            fstart_q <= (row_q == 3'd7);
            state    <= S_LOAD;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ser_data    = data_q;
  assign bus.ser_clk     = sclk_q;
  assign bus.ser_latch   = latch_q;
  assign bus.row_idx     = row_q;
  assign bus.frame_start = fstart_q;
  assign bus.busy        = busy_q;
endmodule
